// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper motion blocks: FSM state codes,
// default step-count width and absolute-position width.
package stepper_pkg;

  localparam int STEP_W_DEFAULT = 9;
  localparam int POS_W          = 16;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t DIR_SETUP = 3'd1;
  localparam state_t PULSE_HI  = 3'd2;
  localparam state_t PULSE_LO  = 3'd3;
  localparam state_t DONE      = 3'd4;

endpackage

// File: rtl/step_pulse_scheduler_phase_counter.sv
// Loadable down-counter with a zero flag; times the DIR setup, STEP high
// and STEP low phases of the pulse scheduler.
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // A phase of N cycles is loaded as N-1 so zero marks its final cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/step_pulse_scheduler.sv
// Two-axis Bresenham STEP/DIR sequencer between the step calculator and the
// driver pins. Define STEP_POS_TRACK_EN to add signed pos1/pos2 position outputs.
module step_pulse_scheduler
  import stepper_pkg::*;
#(
  parameter int STEP_W          = STEP_W_DEFAULT,
  parameter int PULSE_HIGH_CYC  = 50,
  parameter int STEP_PERIOD_CYC = 5000,
  parameter int DIR_SETUP_CYC   = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] steps1,
  input  logic [STEP_W-1:0] steps2,
  input  logic              dir1,
  input  logic              dir2,
  input  logic              abort,
  output logic              step1_out,
  output logic              step2_out,
  output logic              dir1_out,
  output logic              dir2_out,
  output logic              busy,
  output logic              done
`ifdef STEP_POS_TRACK_EN
  ,
  output logic signed [POS_W-1:0] pos1,
  output logic signed [POS_W-1:0] pos2
`endif
);

  localparam int CNT_W = $clog2(STEP_PERIOD_CYC + DIR_SETUP_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(PULSE_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD   = CNT_W'(STEP_PERIOD_CYC - PULSE_HIGH_CYC - 1);

  state_t                 state;
  logic                   major1;
  logic [STEP_W-1:0]      major_cnt;
  logic [STEP_W-1:0]      minor_cnt;
  logic [STEP_W-1:0]      remaining;
  logic signed [STEP_W:0] err;
  logic                   abort_pend;

  logic                   cmd_major1;
  logic [STEP_W-1:0]      cmd_major;
  logic [STEP_W-1:0]      cmd_minor;
  logic                   accept;
  logic                   enter_hi;
  logic                   enter_lo;
  logic                   finish;
  logic signed [STEP_W:0] err_dec;
  logic signed [STEP_W:0] err_inc;
  logic                   minor_step;
  logic                   set1;
  logic                   set2;
  logic                   ph_load;
  logic [CNT_W-1:0]       ph_val;
  logic                   ph_zero;

  phase_counter #(.W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  // Phase transitions; an abort seen during a high phase waits for its end.
  always_comb begin
    cmd_major1 = (steps1 >= steps2);
    cmd_major  = cmd_major1 ? steps1 : steps2;
    cmd_minor  = cmd_major1 ? steps2 : steps1;
    accept     = (state == IDLE) && cmd_valid;
    enter_hi   = 1'b0;
    enter_lo   = 1'b0;
    finish     = 1'b0;
    case (state)
      DIR_SETUP: begin
        if (abort)        finish   = 1'b1;
        else if (ph_zero) enter_hi = 1'b1;
      end
      PULSE_HI: begin
        if (ph_zero) begin
          if (abort || abort_pend) finish   = 1'b1;
          else                     enter_lo = 1'b1;
        end
      end
      PULSE_LO: begin
        if (abort) finish = 1'b1;
        else if (ph_zero) begin
          if (remaining == STEP_W'(1)) finish   = 1'b1;
          else                         enter_hi = 1'b1;
        end
      end
      default: ;
    endcase
    err_dec    = err - $signed({1'b0, minor_cnt});
    err_inc    = err_dec + $signed({1'b0, major_cnt});
    minor_step = err_dec[STEP_W];
    set1       = major1 | minor_step;
    set2       = ~major1 | minor_step;
    ph_load    = accept | enter_hi | enter_lo;
    ph_val     = accept ? SETUP_LOAD : (enter_hi ? HIGH_LOAD : LOW_LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      step1_out  <= 1'b0;
      step2_out  <= 1'b0;
      dir1_out   <= 1'b0;
      dir2_out   <= 1'b0;
      major1     <= 1'b1;
      major_cnt  <= '0;
      minor_cnt  <= '0;
      remaining  <= '0;
      err        <= '0;
      abort_pend <= 1'b0;
    end else begin
      if (accept) begin
        dir1_out   <= dir1;
        dir2_out   <= dir2;
        major1     <= cmd_major1;
        major_cnt  <= cmd_major;
        minor_cnt  <= cmd_minor;
        remaining  <= cmd_major;
        err        <= $signed({1'b0, cmd_major >> 1});
        abort_pend <= 1'b0;
        state      <= (cmd_major == '0) ? DONE : DIR_SETUP;
      end
      if (enter_hi) begin
        state     <= PULSE_HI;
        step1_out <= set1;
        step2_out <= set2;
        err       <= minor_step ? err_inc : err_dec;
      end
      if (enter_lo) begin
        state     <= PULSE_LO;
        step1_out <= 1'b0;
        step2_out <= 1'b0;
      end
      if (finish) begin
        state     <= DONE;
        step1_out <= 1'b0;
        step2_out <= 1'b0;
      end
      if ((state == PULSE_HI) && abort) abort_pend <= 1'b1;
      if ((state == PULSE_LO) && enter_hi) remaining <= remaining - STEP_W'(1);
      if (state == DONE) state <= IDLE;
    end
  end

`ifdef STEP_POS_TRACK_EN
  // STEP outputs are always low before a high phase, so every set is a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos1 <= '0;
      pos2 <= '0;
    end else if (enter_hi) begin
      if (set1) pos1 <= dir1_out ? pos1 + POS_W'(1) : pos1 - POS_W'(1);
      if (set2) pos2 <= dir2_out ? pos2 + POS_W'(1) : pos2 - POS_W'(1);
    end
  end
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_step_pulse_scheduler.sv
// Self-checking bench for step_pulse_scheduler: table vectors, corner sequences
// and random moves against a Bresenham arithmetic model.
module tb_step_pulse_scheduler;

  localparam int STEP_W  = 9;
  localparam int PH      = 2;
  localparam int PP      = 5;
  localparam int PD      = 3;
  localparam int TIMEOUT = 2000;

  typedef struct {
    int s1; int s2; bit d1; bit d2;
    int mode; int atick;
    int p1; int p2; int lat;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] steps1;
  logic [STEP_W-1:0] steps2;
  logic              dir1;
  logic              dir2;
  logic              abort;
  logic              step1_out;
  logic              step2_out;
  logic              dir1_out;
  logic              dir2_out;
  logic              busy;
  logic              done;
`ifdef STEP_POS_TRACK_EN
  logic signed [15:0] pos1;
  logic signed [15:0] pos2;
  int exp_pos1 = 0;
  int exp_pos2 = 0;
`endif

  int checks = 0;
  int errors = 0;
  int res_p1, res_p2, res_lat, res_busy, res_bad_pattern, res_bad_width, res_bad_dir, res_wait;
  int res_post;
  int nxt_s1, nxt_s2;
  bit nxt_d1, nxt_d2;
  vec_t vecs[8];

  always #5 clk = ~clk;

  step_pulse_scheduler #(
    .STEP_W(STEP_W), .PULSE_HIGH_CYC(PH), .STEP_PERIOD_CYC(PP), .DIR_SETUP_CYC(PD)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .steps1(steps1), .steps2(steps2), .dir1(dir1), .dir2(dir2), .abort(abort),
    .step1_out(step1_out), .step2_out(step2_out), .dir1_out(dir1_out), .dir2_out(dir2_out),
    .busy(busy), .done(done)
`ifdef STEP_POS_TRACK_EN
    , .pos1(pos1), .pos2(pos2)
`endif
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Minor-axis steps taken after k major ticks, with the error term starting at major/2.
  function automatic int minor_done(input int maj, input int mnr, input int k);
    if (maj == 0) return 0;
    return (k * mnr - maj / 2 + maj - 1) / maj;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // mode: 0 plain, 1 abort in high phase of tick atick, 2 abort in low phase
  // after tick atick, 3 abort during DIR setup, 4 reset in low phase after tick atick.
  task automatic applyStimulus(input int s1, input int s2, input bit d1, input bit d2,
                               input int mode, input int atick, input bit hold);
    int cyc, ticks, w1, w2, maj, mnr;
    bit maj1, fin, p1q, p2q, r1, r2, any_now, any_prev, mstep, do_reset;
    maj1 = (s1 >= s2);
    maj  = maj1 ? s1 : s2;
    mnr  = maj1 ? s2 : s1;
    res_p1 = 0; res_p2 = 0; res_lat = -1; res_busy = 0;
    res_bad_pattern = 0; res_bad_width = 0; res_bad_dir = 0; res_wait = 0; res_post = -1;
    steps1 = STEP_W'(s1); steps2 = STEP_W'(s2); dir1 = d1; dir2 = d2; cmd_valid = 1'b1;
    while (!cmd_ready && res_wait < TIMEOUT) begin
      @(negedge clk);
      res_wait++;
    end
    @(negedge clk);
    if (hold) begin
      steps1 = STEP_W'(nxt_s1); steps2 = STEP_W'(nxt_s2); dir1 = nxt_d1; dir2 = nxt_d2;
    end else begin
      cmd_valid = 1'b0;
    end
    cyc = 1; ticks = 0; w1 = 0; w2 = 0; p1q = 1'b0; p2q = 1'b0; fin = 1'b0;
    while (!fin && cyc <= TIMEOUT) begin
      abort = (mode == 3) && (cyc == 1);
      do_reset = 1'b0;
      r1 = step1_out && !p1q;
      r2 = step2_out && !p2q;
      any_now  = step1_out || step2_out;
      any_prev = p1q || p2q;
      if ((r1 || r2) && any_prev) res_bad_pattern++;
      if (any_now && !any_prev) begin
        ticks++;
        mstep = minor_done(maj, mnr, ticks) > minor_done(maj, mnr, ticks - 1);
        if (r1 != (maj1 ? 1'b1 : mstep) || r2 != (maj1 ? mstep : 1'b1)) res_bad_pattern++;
        if (ticks > maj) res_bad_pattern++;
        if (mode == 1 && ticks == atick) abort = 1'b1;
      end
      if (any_prev && !any_now) begin
        if (mode == 2 && ticks == atick) abort = 1'b1;
        if (mode == 4 && ticks == atick) do_reset = 1'b1;
      end
      if (step1_out) w1++;
      else if (p1q) begin
        if (w1 != PH) res_bad_width++;
        w1 = 0;
      end
      if (step2_out) w2++;
      else if (p2q) begin
        if (w2 != PH) res_bad_width++;
        w2 = 0;
      end
      res_p1 += int'(r1);
      res_p2 += int'(r2);
      if (dir1_out != d1 || dir2_out != d2) res_bad_dir++;
      if (busy) res_busy++;
      p1q = step1_out;
      p2q = step2_out;
      if (do_reset) begin
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_outputs", {step1_out, step2_out, dir1_out, dir2_out, busy, done}, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_ready", {cmd_ready, busy}, 2);
        fin = 1'b1;
      end else if (done) begin
        res_lat = cyc;
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    abort = 1'b0;
    if (!fin) checkOutput("move_timeout", 0, 1);
    if (mode != 4 && fin) begin
      @(negedge clk);
      res_post = {busy, cmd_ready, done, dir1_out, dir2_out};
    end
  endtask

  task automatic verifyMove(input string tag, input int p1, input int p2, input int lat,
                            input bit d1, input bit d2);
    checkOutput({tag, "_pulses1"}, res_p1, p1);
    checkOutput({tag, "_pulses2"}, res_p2, p2);
    checkOutput({tag, "_latency"}, res_lat, lat);
    checkOutput({tag, "_busy_cycles"}, res_busy, lat);
    checkOutput({tag, "_tick_pattern_errs"}, res_bad_pattern, 0);
    checkOutput({tag, "_pulse_width_errs"}, res_bad_width, 0);
    checkOutput({tag, "_dir_errs"}, res_bad_dir, 0);
    checkOutput({tag, "_post_idle"}, res_post, {1'b0, 1'b1, 1'b0, d1, d2});
`ifdef STEP_POS_TRACK_EN
    exp_pos1 += d1 ? p1 : -p1;
    exp_pos2 += d2 ? p2 : -p2;
    checkOutput({tag, "_pos1"}, int'(pos1), exp_pos1);
    checkOutput({tag, "_pos2"}, int'(pos2), exp_pos2);
`endif
  endtask

  initial begin
    int s1, s2, lat;
    bit d1, d2;
    vecs[0] = '{4, 2, 1'b1, 1'b0, 0, 0, 4, 2, 24};
    vecs[1] = '{0, 0, 1'b1, 1'b1, 0, 0, 0, 0, 1};
    vecs[2] = '{3, 3, 1'b0, 1'b1, 0, 0, 3, 3, 19};
    vecs[3] = '{10, 0, 1'b1, 1'b0, 1, 2, 2, 0, 11};
    vecs[4] = '{2, 5, 1'b0, 1'b1, 0, 0, 2, 5, 29};
    vecs[5] = '{1, 0, 1'b1, 1'b1, 0, 0, 1, 0, 9};
    vecs[6] = '{7, 3, 1'b0, 1'b0, 2, 3, 3, 1, 17};
    vecs[7] = '{5, 4, 1'b1, 1'b0, 3, 0, 0, 0, 2};

    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    steps1 = '0; steps2 = '0; dir1 = 1'b0; dir2 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {step1_out, step2_out, dir1_out, dir2_out, busy, done}, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", {cmd_ready, busy, done}, 4);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s1, vecs[i].s2, vecs[i].d1, vecs[i].d2, vecs[i].mode, vecs[i].atick, 1'b0);
      verifyMove($sformatf("vec%0d", i), vecs[i].p1, vecs[i].p2, vecs[i].lat, vecs[i].d1, vecs[i].d2);
    end

    applyStimulus(6, 0, 1'b1, 1'b1, 4, 3, 1'b0);
`ifdef STEP_POS_TRACK_EN
    exp_pos1 = 0;
    exp_pos2 = 0;
    checkOutput("reset_pos", {16'(pos1), 16'(pos2)}, 0);
`endif

    nxt_s1 = 2; nxt_s2 = 1; nxt_d1 = 1'b0; nxt_d2 = 1'b1;
    applyStimulus(3, 1, 1'b1, 1'b1, 0, 0, 1'b1);
    verifyMove("hold_first", 3, 1, 19, 1'b1, 1'b1);
    applyStimulus(2, 1, 1'b0, 1'b1, 0, 0, 1'b0);
    checkOutput("hold_accept_wait", res_wait, 0);
    verifyMove("hold_second", 2, 1, 14, 1'b0, 1'b1);

    for (int n = 0; n < 16; n++) begin
      s1 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 14));
      s2 = int'($urandom_range(0, 14));
      d1 = 1'($urandom);
      d2 = 1'($urandom);
      lat = (s1 == 0 && s2 == 0) ? 1 : PD + ((s1 >= s2) ? s1 : s2) * PP + 1;
      applyStimulus(s1, s2, d1, d2, 0, 0, 1'b0);
      verifyMove($sformatf("rand%0d_%0dx%0d", n, s1, s2), s1, s2, lat, d1, d2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
